// File: rtl/uart_pkg.sv
// Shared UART definitions used by the TX scheduler, frame counter and RX.
//   uart_state_e : frame state encoding (IDLE/START/DATA/STOP)
//   OVERSAMPLE   : baud_clk cycles per bit
//   SAMPLE_LAST  : last oversample phase within a bit
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam logic [3:0]  SAMPLE_LAST = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick for the TX scheduler.
//   req_i   : per-requester request levels
//   ptr_i   : index of the last winner; search starts at ptr_i+1 and wraps
//   gnt_o   : one-hot winner (zero when nothing requests)
//   idx_o   : winner index
//   valid_o : at least one request present
module uart_rr_arbiter #(
  parameter int unsigned NumReq = 4
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [2:0]        ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [2:0]        idx_o,
  output logic              valid_o
);

  localparam int unsigned SelW = (NumReq > 1) ? $clog2(NumReq) : 1;

  int unsigned     cand;
  logic [SelW-1:0] cand_sel;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_sel = '0;
    // Offsets 1..NumReq visit every requester once, the previous winner last.
    for (int unsigned off = 1; off <= NumReq; off++) begin
      cand     = (32'(ptr_i) + off) % NumReq;
      cand_sel = SelW'(cand);
      if (!valid_o && req_i[cand_sel]) begin
        valid_o         = 1'b1;
        idx_o           = 3'(cand);
        gnt_o[cand_sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: round-robin shares one TX line among NUM_REQ requesters and
// sequences each granted byte through START/DATA/STOP on the 16x oversample clock.
//   baud_clk, rst_n : 16x oversample clock, asynchronous active-low reset
//   req, req_data   : per-requester request level and byte (requester i at [i*DATA_W +: DATA_W])
//   grant, grant_id : one-cycle one-hot acceptance pulse, owner of the current frame
//   busy, tx        : not-idle flag, registered serial line (idle high)
//   current_state, sample_count, bit_count, frame_done : frame progress for status logic
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                      baud_clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [2:0]                grant_id,
  output logic                      busy,
  output logic                      tx,
  output logic [1:0]                current_state,
  output logic [3:0]                sample_count,
  output logic [3:0]                bit_count,
  output logic                      frame_done
);

  localparam logic [3:0] DataLast = 4'(DATA_W - 1);
  localparam logic [3:0] StopLast = 4'(STOP_BITS - 1);

  uart_state_e        state_q, state_d;
  logic [3:0]         sample_q, sample_d;
  logic [3:0]         bit_q, bit_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [2:0]         gid_q, gid_d;
  logic [2:0]         ptr_q, ptr_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [2:0]         arb_idx;
  logic               arb_valid;
  logic [DATA_W-1:0]  win_data;
  logic               sample_wrap;
  logic               stop_end;
  logic               arb_point;

  uart_rr_arbiter #(
    .NumReq (NUM_REQ)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == 3'(i)) win_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign sample_wrap = (sample_q == SAMPLE_LAST);
  assign stop_end    = (state_q == STOP) && sample_wrap && (bit_q == StopLast);
  // Arbitrating on the last STOP cycle lets a pending request start with no idle gap.
  assign arb_point   = (state_q == IDLE) || stop_end;

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    grant_d  = '0;
    gid_d    = gid_q;
    ptr_d    = ptr_q;

    if (state_q != IDLE) sample_d = sample_q + 4'd1;

    case (state_q)
      START: begin
        if (sample_wrap) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA: begin
        if (sample_wrap) begin
          if (bit_q == DataLast) begin
            state_d = STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 4'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      STOP: begin
        if (sample_wrap && (bit_q != StopLast)) bit_d = bit_q + 4'd1;
      end
      default: ;
    endcase

    if (arb_point) begin
      sample_d = '0;
      bit_d    = '0;
      if (arb_valid) begin
        state_d = START;
        tx_d    = 1'b0;
        shift_d = win_data;
        grant_d = arb_gnt;
        gid_d   = arb_idx;
        ptr_d   = arb_idx;
      end else begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sample_q <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      grant_q  <= '0;
      gid_q    <= '0;
      ptr_q    <= 3'(NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      grant_q  <= grant_d;
      gid_q    <= gid_d;
      ptr_q    <= ptr_d;
    end
  end

  assign grant         = grant_q;
  assign grant_id      = gid_q;
  assign busy          = (state_q != IDLE);
  assign tx            = tx_q;
  assign current_state = state_q;
  assign sample_count  = sample_q;
  assign bit_count     = bit_q;
  assign frame_done    = stop_end;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: stimulus pushes the expected frame (owner, byte, back-to-back flag);
// a monitor pops it on every grant and checks the whole frame bit by bit.
module tb_uart_tx_scheduler;

  logic        baud_clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [2:0]  grant_id;
  logic        busy, tx, frame_done;
  logic [1:0]  current_state;
  logic [3:0]  sample_count, bit_count;

  // Second instance: 7 data bits, 2 stop bits, 2 requesters.
  logic [1:0]  req2;
  logic [13:0] req_data2;
  logic [1:0]  grant2;
  logic [2:0]  grant_id2;
  logic        busy2, tx2, frame_done2;
  logic [1:0]  current_state2;
  logic [3:0]  sample_count2, bit_count2;

  always #5 baud_clk = ~baud_clk;

  uart_tx_scheduler #(.NUM_REQ(4), .DATA_W(8), .STOP_BITS(1)) u_dut (
    .baud_clk      (baud_clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_data      (req_data),
    .grant         (grant),
    .grant_id      (grant_id),
    .busy          (busy),
    .tx            (tx),
    .current_state (current_state),
    .sample_count  (sample_count),
    .bit_count     (bit_count),
    .frame_done    (frame_done)
  );

  uart_tx_scheduler #(.NUM_REQ(2), .DATA_W(7), .STOP_BITS(2)) u_dut2 (
    .baud_clk      (baud_clk),
    .rst_n         (rst_n),
    .req           (req2),
    .req_data      (req_data2),
    .grant         (grant2),
    .grant_id      (grant_id2),
    .busy          (busy2),
    .tx            (tx2),
    .current_state (current_state2),
    .sample_count  (sample_count2),
    .bit_count     (bit_count2),
    .frame_done    (frame_done2)
  );

  typedef struct {
    logic [2:0] id;
    logic [7:0] data;
    bit         b2b;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_start = 0;
  int   frames_done = 0;

  always @(posedge baud_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [2:0] id, input logic [7:0] data, input bit b2b);
    exp_t e;
    e.id   = id;
    e.data = data;
    e.b2b  = b2b;
    q.push_back(e);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k = 0;
    while (frames_done < target && k < budget) begin
      @(negedge baud_clk);
      k++;
    end
    chk("frames_complete", frames_done, target);
  endtask

  task automatic do_reset();
    @(negedge baud_clk);
    rst_n = 1'b0;
    repeat (2) @(negedge baud_clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one full 160-cycle frame per grant; reset abandons the frame.
  initial begin
    exp_t       e;
    logic [9:0] fb;
    int         bitn;
    bit         aborted;
    forever begin
      @(negedge baud_clk);
      if (rst_n && grant != '0) begin
        if (q.size() == 0) begin
          chk("unexpected_grant", 32'(grant), 0);
          continue;
        end
        e  = q.pop_front();
        fb = {1'b1, e.data, 1'b0};
        chk("grant_onehot", 32'(grant), 32'(4'b0001 << e.id));
        chk("grant_id", 32'(grant_id), 32'(e.id));
        if (e.b2b) chk("frame_period", cyc - last_start, 160);
        last_start = cyc;
        aborted    = 1'b0;
        for (int off = 0; off < 160; off++) begin
          if (off > 0) @(negedge baud_clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          bitn = off / 16;
          if (off == 1) chk("grant_pulse", 32'(grant), 0);
          if (off == 80) chk("busy", 32'(busy), 1);
          if (off % 16 == 8) begin
            chk("tx_bit", 32'(tx), 32'(fb[bitn]));
            chk("state", 32'(current_state), (bitn == 0) ? 1 : (bitn == 9) ? 3 : 2);
            chk("bit_count", 32'(bit_count), (bitn >= 1 && bitn <= 8) ? bitn - 1 : 0);
            chk("sample_count", 32'(sample_count), 8);
          end
          if (off == 159) chk("frame_done", 32'(frame_done), 1);
          else if (off % 16 == 15) chk("frame_done_early", 32'(frame_done), 0);
        end
        if (!aborted) frames_done++;
      end
    end
  end

  initial begin
    int         g;
    int         t;
    int         gt;
    logic [9:0] fb2;
    int         stop_cnt;

    rst_n     = 1'b0;
    req       = '0;
    req_data  = '0;
    req2      = '0;
    req_data2 = '0;

    // Reset values
    @(negedge baud_clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_state", 32'(current_state), 0);
    chk("rst_sample", 32'(sample_count), 0);
    chk("rst_bit", 32'(bit_count), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    @(negedge baud_clk);
    rst_n = 1'b1;

    // Single frame, requester 0, 0xA5; grant one cycle after the request
    @(negedge baud_clk);
    req_data[7:0] = 8'hA5;
    req           = 4'b0001;
    push(3'd0, 8'hA5, 1'b0);
    @(negedge baud_clk);
    chk("latency_grant", 32'(grant), 32'h1);
    chk("latency_tx", 32'(tx), 0);
    req = '0;
    wait_frames(1, 400);

    // All four requesting: order 0,1,2,3,0, back to back; r0 data changed mid-frame
    do_reset();
    @(negedge baud_clk);
    req_data = {8'hF0, 8'h0F, 8'h3C, 8'h96};
    req      = 4'b1111;
    push(3'd0, 8'h96, 1'b0);
    push(3'd1, 8'h3C, 1'b1);
    push(3'd2, 8'h0F, 1'b1);
    push(3'd3, 8'hF0, 1'b1);
    push(3'd0, 8'h5A, 1'b1);
    g  = 0;
    gt = -1;
    for (t = 0; t < 1000; t++) begin
      @(negedge baud_clk);
      if (grant != '0) begin
        g++;
        if (g == 1) gt = t;
        if (g == 5) begin
          req = '0;
          break;
        end
      end
      if (gt >= 0 && t == gt + 40) req_data[7:0] = 8'h5A;
    end
    wait_frames(6, 1000);

    // Requester 2 arrives during requester 1's DATA phase
    do_reset();
    @(negedge baud_clk);
    req_data[15:8] = 8'h81;
    req            = 4'b0010;
    push(3'd1, 8'h81, 1'b0);
    @(negedge baud_clk);
    req = '0;
    repeat (60) @(negedge baud_clk);
    req_data[23:16] = 8'h6E;
    req             = 4'b0100;
    push(3'd2, 8'h6E, 1'b1);
    for (t = 0; t < 300; t++) begin
      @(negedge baud_clk);
      if (grant[2]) begin
        req = '0;
        break;
      end
    end
    wait_frames(8, 500);

    // Reset during DATA bit 3, then a fresh frame for requester 1
    @(negedge baud_clk);
    req_data[23:16] = 8'hF7;
    req             = 4'b0100;
    push(3'd2, 8'hF7, 1'b0);
    @(negedge baud_clk);
    req = '0;
    repeat (69) @(negedge baud_clk);
    chk("pre_reset_tx", 32'(tx), 0);
    chk("pre_reset_bit", 32'(bit_count), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx), 1);
    chk("mid_rst_state", 32'(current_state), 0);
    chk("mid_rst_sample", 32'(sample_count), 0);
    chk("mid_rst_bit", 32'(bit_count), 0);
    chk("mid_rst_grant_id", 32'(grant_id), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    repeat (2) @(negedge baud_clk);
    rst_n          = 1'b1;
    req_data[15:8] = 8'h4B;
    req            = 4'b0010;
    push(3'd1, 8'h4B, 1'b0);
    @(negedge baud_clk);
    chk("post_rst_grant", 32'(grant), 32'h2);
    req = '0;
    wait_frames(9, 400);

    // 7 data bits, 2 stop bits, byte 0x7F: 160-cycle frame with a 32-cycle STOP
    @(negedge baud_clk);
    req_data2 = {7'h00, 7'h7F};
    req2      = 2'b01;
    fb2       = {2'b11, 7'h7F, 1'b0};
    stop_cnt  = 0;
    @(negedge baud_clk);
    chk("d2_grant", 32'(grant2), 1);
    req2 = '0;
    for (int off = 0; off < 160; off++) begin
      if (off > 0) @(negedge baud_clk);
      if (current_state2 == 2'b11) stop_cnt++;
      if (off % 16 == 8) chk("d2_tx_bit", 32'(tx2), 32'(fb2[off/16]));
      if (off == 136) chk("d2_stop_bit0", 32'(bit_count2), 0);
      if (off == 152) chk("d2_stop_bit1", 32'(bit_count2), 1);
      if (off == 143) chk("d2_frame_done_early", 32'(frame_done2), 0);
      if (off == 159) chk("d2_frame_done", 32'(frame_done2), 1);
    end
    @(negedge baud_clk);
    chk("d2_idle_after", 32'(current_state2), 0);
    chk("d2_stop_len", stop_cnt, 32);
    chk("d2_tx_idle", 32'(tx2), 1);

    chk("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
